gen_signal_mc: RTL

Parametrised successor of the single-channel ADC timing generator. Produces per-channel conversion pulses (`cnv`), a gated ADC serial-clock burst (`adcclk`) and a bit-sample strobe for the downstream deserialiser. Supports continuous and triggered frame modes and a per-channel enable mask. Sits between the 800 MHz system clock domain and the ADC pins/readout logic.

---
 rtl/gen_signal_pkg.sv | 38 +++
 rtl/adc_clk_burst.sv | 96 +++++++++
 rtl/gen_signal_mc.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gen_signal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gen_signal_pkg
// Purpose  : Shared types and helpers for the multi-channel ADC timing
//            generator: FSM state encoding, read-window length and bit-index
//            width helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gen_signal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CNV       = 3'd1,
    ST_CONV_WAIT = 3'd2,
    ST_READ      = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  localparam int unsigned BITS_DEF     = 16;
  localparam int unsigned DIV_DEF      = 4;
  localparam int unsigned READ_LEN_DEF = BITS_DEF * DIV_DEF;
  localparam int unsigned IDX_W_DEF    = $clog2(BITS_DEF);

  // Number of clk cycles the serial-clock burst occupies.
  function automatic int unsigned read_len(input int unsigned bits,
                                           input int unsigned div);
    return bits * div;
  endfunction

  // Width of bit_idx; kept at least one bit so a single-bit frame still
  // has a legal port.
  function automatic int unsigned idx_w(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_clk_burst.sv
`default_nettype none
// ============================================================================
// Module   : adc_clk_burst
// Purpose  : Generates a burst of BITS serial-clock periods of DIV clk cycles
//            each, plus a strobe in the last phase of every period.
// Ports    : clk_i        - system clock
//            rst_ni       - asynchronous active-low reset
//            start_i      - pulse in the cycle before the first burst cycle
//            adcclk_o     - serial clock, high for the first DIV/2 phases
//            bit_strobe_o - one-cycle sample strobe in phase DIV-1
//            bit_idx_o    - index of the bit sampled on bit_strobe_o
//            last_o       - high together with the final strobe
// Revision : 1.0 - initial release
// ============================================================================
module adc_clk_burst
  import gen_signal_pkg::*;
#(
  parameter int unsigned BITS = 16,
  parameter int unsigned DIV  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     adcclk_o,
  output logic                     bit_strobe_o,
  output logic [idx_w(BITS)-1:0]   bit_idx_o,
  output logic                     last_o
);

  localparam int unsigned IDX_W = idx_w(BITS);
  localparam int unsigned PH_W  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PH_W-1:0]  P_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  P_HALF = PH_W'(DIV / 2);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(BITS - 1);

  logic             active_q, active_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             adcclk_q, adcclk_d;
  logic             strobe_q, strobe_d;
  logic             last_q, last_d;

  // Outputs are computed from the next phase/bit so that the registered
  // value lines up with the cycle the phase counter describes.
  always_comb begin
    active_d = active_q;
    ph_d     = ph_q;
    k_d      = k_q;
    if (start_i) begin
      active_d = 1'b1;
      ph_d     = '0;
      k_d      = '0;
    end else if (active_q) begin
      if (ph_q == P_LAST) begin
        ph_d = '0;
        if (k_q == K_LAST) begin
          active_d = 1'b0;
          k_d      = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
    adcclk_d = active_d && (ph_d < P_HALF);
    strobe_d = active_d && (ph_d == P_LAST);
    last_d   = strobe_d && (k_d == K_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      ph_q     <= '0;
      k_q      <= '0;
      adcclk_q <= 1'b0;
      strobe_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      ph_q     <= ph_d;
      k_q      <= k_d;
      adcclk_q <= adcclk_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
    end
  end

  assign adcclk_o     = adcclk_q;
  assign bit_strobe_o = strobe_q;
  assign bit_idx_o    = k_q;
  assign last_o       = last_q;

endmodule
`default_nettype wire

// File: rtl/gen_signal_mc.sv
`default_nettype none
// ============================================================================
// Module   : gen_signal_mc
// Purpose  : Multi-channel ADC timing generator. Issues per-channel
//            conversion pulses, a gated serial-clock burst with sample
//            strobes, in continuous or triggered frame mode.
// Ports    : clk_i        - system clock
//            rst_ni       - asynchronous active-low reset
//            enable_i     - run enable
//            mode_i       - 0 continuous, 1 triggered (sampled at frame start)
//            trig_i       - single-cycle frame request
//            ch_en_i      - channel enable mask (sampled at frame start)
//            cnv_o        - conversion pulses, one per channel
//            adcclk_o     - ADC serial clock, idle low
//            bit_strobe_o - data-sample strobe
//            bit_idx_o    - bit index on strobe, 0 = MSB
//            frame_done_o - end-of-readout pulse
//            busy_o       - frame in progress, including gap
//            overrun_o    - pulse on a rejected trigger
// Revision : 1.0 - initial release
// ============================================================================
module gen_signal_mc
  import gen_signal_pkg::*;
#(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned BITS    = 16,
  parameter int unsigned DIV     = 4,
  parameter int unsigned T_CNV   = 8,
  parameter int unsigned T_CONV  = 520,
  parameter int unsigned T_FRAME = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   mode_i,
  input  logic                   trig_i,
  input  logic [CH_NUM-1:0]      ch_en_i,
  output logic [CH_NUM-1:0]      cnv_o,
  output logic                   adcclk_o,
  output logic                   bit_strobe_o,
  output logic [idx_w(BITS)-1:0] bit_idx_o,
  output logic                   frame_done_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int unsigned READ_LEN = read_len(BITS, DIV);

  localparam logic [CNT_W-1:0] FC_CNV_LAST   = CNT_W'(T_CNV - 1);
  localparam logic [CNT_W-1:0] FC_CONV_LAST  = CNT_W'(T_CONV - 1);
  localparam logic [CNT_W-1:0] FC_FRAME_LAST = CNT_W'(T_FRAME - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (CH_NUM < 1) begin : g_bad_ch_num
    $error("gen_signal_mc: CH_NUM must be >= 1");
  end
  if (BITS < 1) begin : g_bad_bits
    $error("gen_signal_mc: BITS must be >= 1");
  end
  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("gen_signal_mc: DIV must be even and >= 2");
  end
  if (T_CNV < 1) begin : g_bad_t_cnv
    $error("gen_signal_mc: T_CNV must be >= 1");
  end
  if (T_CONV <= T_CNV) begin : g_bad_t_conv
    $error("gen_signal_mc: T_CONV must exceed T_CNV");
  end
  if (T_FRAME < (T_CONV + READ_LEN + 1)) begin : g_bad_t_frame
    $error("gen_signal_mc: T_FRAME must be >= T_CONV + BITS*DIV + 1");
  end
  if ((CNT_W >= 63) || ((64'd1 << CNT_W) <= 64'(T_FRAME))) begin : g_bad_cnt_w
    $error("gen_signal_mc: 2**CNT_W must exceed T_FRAME");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   fc_q, fc_d;
  logic [CH_NUM-1:0]  mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [CH_NUM-1:0]  cnv_q, cnv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;

  logic               start_cond;
  logic               cont_restart;
  logic               burst_start;
  logic               burst_last;

  // Start condition evaluated in IDLE; the trigger only matters in
  // triggered mode.
  assign start_cond   = enable_i && (ch_en_i != '0) && (mode_i ? trig_i : 1'b1);
  // Back-to-back frames only chain while both the running frame and the
  // current mode input are continuous.
  assign cont_restart = !mode_q && !mode_i && enable_i && (ch_en_i != '0);

  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    burst_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        fc_d = '0;
        if (start_cond) begin
          state_d = ST_CNV;
          mask_d  = ch_en_i;
          mode_d  = mode_i;
        end
      end
      ST_CNV: begin
        fc_d = fc_q + 1'b1;
        if (fc_q == FC_CNV_LAST) begin
          state_d = ST_CONV_WAIT;
        end
      end
      ST_CONV_WAIT: begin
        fc_d = fc_q + 1'b1;
        if (fc_q == FC_CONV_LAST) begin
          state_d     = ST_READ;
          burst_start = 1'b1;
        end
      end
      ST_READ: begin
        fc_d = fc_q + 1'b1;
        // The burst flags its final strobe; the following cycle is the
        // first gap cycle and carries frame_done.
        if (burst_last) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (fc_q == FC_FRAME_LAST) begin
          fc_d = '0;
          if (cont_restart) begin
            state_d = ST_CNV;
            mask_d  = ch_en_i;
            mode_d  = mode_i;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fc_d    = '0;
      end
    endcase

    // Outputs are registered from the next state so each output reflects
    // the frame position of the cycle it is visible in.
    cnv_d  = (state_d == ST_CNV) ? mask_d : '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_READ) && (state_d == ST_GAP);
    ovr_d  = trig_i && mode_i && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      fc_q    <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      cnv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      cnv_q   <= cnv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Serial-clock burst
  // --------------------------------------------------------------------------
  adc_clk_burst #(
    .BITS (BITS),
    .DIV  (DIV)
  ) u_burst (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (burst_start),
    .adcclk_o     (adcclk_o),
    .bit_strobe_o (bit_strobe_o),
    .bit_idx_o    (bit_idx_o),
    .last_o       (burst_last)
  );

  assign cnv_o        = cnv_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign overrun_o    = ovr_q;

endmodule
`default_nettype wire
